// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory req/ack, branch redirect and the
// decode-side valid/ready queue head. The fetch queue is the master.
interface inst_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [ILEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;
    logic [CW-1:0]   out_count;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_count,
        output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time to
// instruction memory and buffers returned words with their PCs for decode.
module inst_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    inst_fetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t          state, state_next;
    logic            req_q, req_next;
    logic [XLEN-1:0] addr_q, addr_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [XLEN-1:0] target_pc, target_next;
    logic [CW-1:0]   count, count_next;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [ILEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    logic            push, pop, flush, credit;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] fetch_pc_inc;

    assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign fetch_pc_inc = fetch_pc + XLEN'(4);
    assign flush        = bus.redirect;
    // A redirect wins over both a returning word and a decode pop.
    assign push         = (state == WAIT) && bus.imem_ack && !bus.redirect;
    assign pop          = (count != '0) && bus.out_ready && !bus.redirect;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Any outstanding request has already retired when credit is evaluated,
    // so one free slot after this cycle's push/pop is enough to issue.
    assign credit = (count_next < CW'(DEPTH));

    always_comb begin
        state_next    = state;
        req_next      = req_q;
        addr_next     = addr_q;
        fetch_pc_next = fetch_pc;
        target_next   = target_pc;
        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_next = redirect_tgt;
                end else if (credit) begin
                    req_next   = 1'b1;
                    addr_next  = fetch_pc;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    if (bus.imem_ack) begin
                        req_next      = 1'b0;
                        fetch_pc_next = redirect_tgt;
                        state_next    = IDLE;
                    end else begin
                        target_next = redirect_tgt;
                        state_next  = DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    fetch_pc_next = fetch_pc_inc;
                    if (credit) begin
                        addr_next = fetch_pc_inc;
                    end else begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    req_next      = 1'b0;
                    fetch_pc_next = bus.redirect ? redirect_tgt : target_pc;
                    state_next    = IDLE;
                end else if (bus.redirect) begin
                    target_next = redirect_tgt;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
        end else begin
            state     <= state_next;
            req_q     <= req_next;
            addr_q    <= addr_next;
            fetch_pc  <= fetch_pc_next;
            target_pc <= target_next;
        end
    end

    // Queue bookkeeping; a flush simply rewinds both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_inst[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]   <= addr_q;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = mem_inst[rd_ptr];
    assign bus.out_pc    = mem_pc[rd_ptr];
    assign bus.out_count = count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a scoreboard of acknowledged words
// is matched against what decode pops, plus per-scenario protocol checks.
module tb_inst_fetch_queue;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    bit   drain_pending;

    inst_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) fetch_bus ();
    inst_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) wrap_bus ();

    inst_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fetch_bus.master)
    );

    inst_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wrap_bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] addr);
        return addr ^ 32'h5A5A_A5A5;
    endfunction

    // Drives one cycle of memory/decode/redirect behaviour from a negedge and keeps
    // the scoreboard in step: acknowledged words are pushed, decode pops compared.
    task automatic applyStimulus(input bit ack_en, input bit ready, input bit redir,
                                 input logic [XLEN-1:0] rpc);
        bit   ack;
        exp_t exp;
        ack = ack_en && (fetch_bus.imem_req === 1'b1);
        fetch_bus.imem_ack    = ack;
        fetch_bus.imem_rdata  = inst_of(fetch_bus.imem_addr);
        fetch_bus.out_ready   = ready;
        fetch_bus.redirect    = redir;
        fetch_bus.redirect_pc = rpc;
        if (fetch_bus.out_valid === 1'b1 && ready && !redir) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_pop: popped pc=%h but required no entry", fetch_bus.out_pc);
            end else begin
                exp = sb.pop_front();
                if (fetch_bus.out_pc !== exp.pc || fetch_bus.out_inst !== exp.inst) begin
                    errors++;
                    $display("[TB] FAIL sb_data: got pc=%h inst=%h required pc=%h inst=%h",
                             fetch_bus.out_pc, fetch_bus.out_inst, exp.pc, exp.inst);
                end
            end
        end
        if (redir) begin
            sb.delete();
            drain_pending = (fetch_bus.imem_req === 1'b1) && !ack;
        end else if (ack) begin
            if (drain_pending) begin
                drain_pending = 1'b0;
            end else begin
                exp.pc   = fetch_bus.imem_addr;
                exp.inst = inst_of(fetch_bus.imem_addr);
                sb.push_back(exp);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fetch_bus.out_count !== CW'(sb.size()) || fetch_bus.out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("[TB] FAIL occupancy: got count=%0d valid=%b required count=%0d",
                     fetch_bus.out_count, fetch_bus.out_valid, sb.size());
        end
    endtask

    task automatic reset_dut();
        fetch_bus.imem_ack    = 1'b0;
        fetch_bus.imem_rdata  = '0;
        fetch_bus.redirect    = 1'b0;
        fetch_bus.redirect_pc = '0;
        fetch_bus.out_ready   = 1'b0;
        wrap_bus.imem_ack     = 1'b0;
        wrap_bus.imem_rdata   = '0;
        wrap_bus.redirect     = 1'b0;
        wrap_bus.redirect_pc  = '0;
        wrap_bus.out_ready    = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        drain_pending = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (fetch_bus.imem_req !== 1'b0 || fetch_bus.imem_addr !== 32'h0 ||
            fetch_bus.out_valid !== 1'b0 || fetch_bus.out_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got req=%b addr=%h valid=%b count=%0d required 0/0/0/0",
                     fetch_bus.imem_req, fetch_bus.imem_addr, fetch_bus.out_valid, fetch_bus.out_count);
        end
        checks++;
        if (wrap_bus.imem_addr !== 32'hFFFF_FFFC || wrap_bus.imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pc: got addr=%h req=%b required fffffffc/0",
                     wrap_bus.imem_addr, wrap_bus.imem_req);
        end
    endtask

    task automatic test_stream();
        logic [XLEN-1:0] exp_addr;
        reset_dut();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        exp_addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (fetch_bus.imem_req !== 1'b1 || fetch_bus.imem_addr !== exp_addr) begin
                errors++;
                $display("[TB] FAIL stream_addr: got req=%b addr=%h required 1/%h",
                         fetch_bus.imem_req, fetch_bus.imem_addr, exp_addr);
            end
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
            exp_addr = exp_addr + 32'd4;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_full();
        int acks;
        reset_dut();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (fetch_bus.imem_req === 1'b1) acks++;
            applyStimulus(1'b1, 1'b0, 1'b0, '0);
        end
        checks++;
        if (acks !== DEPTH || fetch_bus.imem_req !== 1'b0 || fetch_bus.out_count !== CW'(DEPTH)) begin
            errors++;
            $display("[TB] FAIL full_stop: got acks=%0d req=%b count=%0d required %0d/0/%0d",
                     acks, fetch_bus.imem_req, fetch_bus.out_count, DEPTH, DEPTH);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (fetch_bus.imem_req !== 1'b1 || fetch_bus.imem_addr !== 32'h10) begin
            errors++;
            $display("[TB] FAIL full_resume: got req=%b addr=%h required 1/00000010",
                     fetch_bus.imem_req, fetch_bus.imem_addr);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect_wait();
        bit found;
        reset_dut();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (fetch_bus.imem_req === 1'b1 && fetch_bus.imem_addr === 32'h8) found = 1'b1;
            else applyStimulus(1'b1, 1'b1, 1'b0, '0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reach_addr8: got addr=%h required 00000008", fetch_bus.imem_addr);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fetch_bus.imem_req !== 1'b1 || fetch_bus.imem_addr !== 32'h8 || fetch_bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL drain_hold: got req=%b addr=%h valid=%b required 1/00000008/0",
                         fetch_bus.imem_req, fetch_bus.imem_addr, fetch_bus.out_valid);
            end
            if (i < 2) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5 && fetch_bus.imem_req !== 1'b1; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (fetch_bus.imem_req !== 1'b1 || fetch_bus.imem_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL drain_target: got req=%b addr=%h required 1/00000100",
                     fetch_bus.imem_req, fetch_bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect_ack_pop();
        reset_dut();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (fetch_bus.out_count !== CW'(2) || fetch_bus.imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_redirect: got count=%0d req=%b required 2/1",
                     fetch_bus.out_count, fetch_bus.imem_req);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        checks++;
        if (fetch_bus.out_count !== '0 || fetch_bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redirect_flush: got count=%0d valid=%b required 0/0",
                     fetch_bus.out_count, fetch_bus.out_valid);
        end
        for (int i = 0; i < 5 && fetch_bus.imem_req !== 1'b1; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (fetch_bus.imem_req !== 1'b1 || fetch_bus.imem_addr !== 32'h200) begin
            errors++;
            $display("[TB] FAIL redirect_target: got req=%b addr=%h required 1/00000200",
                     fetch_bus.imem_req, fetch_bus.imem_addr);
        end
    endtask

    task automatic test_redirect_align();
        reset_dut();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h103);
        checks++;
        if (fetch_bus.imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_redirect_req: got req=%b required 0", fetch_bus.imem_req);
        end
        for (int i = 0; i < 5 && fetch_bus.imem_req !== 1'b1; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (fetch_bus.imem_req !== 1'b1 || fetch_bus.imem_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL align_target: got req=%b addr=%h required 1/00000100",
                     fetch_bus.imem_req, fetch_bus.imem_addr);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (fetch_bus.imem_addr !== 32'h104) begin
            errors++;
            $display("[TB] FAIL align_next: got addr=%h required 00000104", fetch_bus.imem_addr);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_pc_wrap();
        logic [XLEN-1:0] exp_addr [3];
        reset_dut();
        exp_addr[0] = 32'hFFFF_FFFC;
        exp_addr[1] = 32'h0000_0000;
        exp_addr[2] = 32'h0000_0004;
        wrap_bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wrap_bus.imem_req !== 1'b1 || wrap_bus.imem_addr !== exp_addr[i]) begin
                errors++;
                $display("[TB] FAIL wrap_addr: got req=%b addr=%h required 1/%h",
                         wrap_bus.imem_req, wrap_bus.imem_addr, exp_addr[i]);
            end
            if (i > 0) begin
                checks++;
                if (wrap_bus.out_valid !== 1'b1 || wrap_bus.out_pc !== exp_addr[i-1] ||
                    wrap_bus.out_inst !== inst_of(exp_addr[i-1])) begin
                    errors++;
                    $display("[TB] FAIL wrap_out: got valid=%b pc=%h inst=%h required 1/%h/%h",
                             wrap_bus.out_valid, wrap_bus.out_pc, wrap_bus.out_inst,
                             exp_addr[i-1], inst_of(exp_addr[i-1]));
                end
            end
            wrap_bus.imem_ack   = 1'b1;
            wrap_bus.imem_rdata = inst_of(wrap_bus.imem_addr);
            @(posedge clk);
            @(negedge clk);
        end
        wrap_bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset_wait();
        reset_dut();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (fetch_bus.out_count !== CW'(3) || fetch_bus.imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset: got count=%0d req=%b required 3/1",
                     fetch_bus.out_count, fetch_bus.imem_req);
        end
        fetch_bus.imem_ack   = 1'b1;
        fetch_bus.imem_rdata = inst_of(fetch_bus.imem_addr);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fetch_bus.imem_req !== 1'b0 || fetch_bus.out_count !== '0 ||
            fetch_bus.imem_addr !== 32'h0 || fetch_bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_wait: got req=%b count=%0d addr=%h valid=%b required 0/0/0/0",
                     fetch_bus.imem_req, fetch_bus.out_count, fetch_bus.imem_addr, fetch_bus.out_valid);
        end
        fetch_bus.imem_ack = 1'b0;
        rst = 1'b0;
        sb.delete();
        drain_pending = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drain_pending = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_redirect_align();
        test_pc_wrap();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
